kt_job_scheduler: RTL
=====================

Name: kt_job_scheduler

Overview:
- Front-end controller for the knight-tour solver core; the core solves one tour at a time.
- Accepts tour jobs (fixed path prefix plus direction priority) from two requesters through per-requester valid/ready streams and arbitrates round-robin.
- Buffers the granted prefix, then replays it to the core as one contiguous in_valid burst.
- Forwards the core's 25-step result burst to a shared result port, tagged with the requester id.

Parameters:
- TIMEOUT, 4096: max cycles in WAIT for the first kt_out_valid before halting.
- GAP, 2: idle cycles enforced between the end of DRAIN and the next kt_in_valid.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- reqN_valid  in  1  (N=0,1) prefix entry valid
- reqN_ready  out  1  entry accepted when valid&ready
- reqN_x, reqN_y  in  3 each  entry coordinate, 0..4
- reqN_prio  in  3  priority direction; sampled with the job's first entry
- reqN_last  in  1  final prefix entry of the job
- kt_in_valid  out  1  core input strobe
- kt_in_x, kt_in_y  out  3 each  prefix coordinate to core
- kt_move_num  out  5  prefix length; meaningful on first burst cycle only
- kt_priority_num  out  3  priority; meaningful on first burst cycle only
- kt_out_valid  in  1  core result strobe
- kt_out_x, kt_out_y  in  3 each  core result coordinate
- kt_move_out  in  5  core step index, 1..25
- res_valid  out  1  result entry valid; no backpressure
- res_id  out  1  requester that owns the result
- res_step  out  5  step index 1..25
- res_x, res_y  out  3 each  result coordinate
- res_last  out  1  high with step 25
- busy  out  1  high in any state other than IDLE
- err_len  out  1  1-cycle pulse: prefix truncated at 25 entries
- err_coord  out  1  1-cycle pulse: job discarded for an out-of-range coordinate
- err_timeout  out  1  1-cycle pulse on entry to HALT

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant=1, so req0 wins the first tie; buffer count 0.
- Reset mid-operation aborts any job immediately; the partially loaded buffer is discarded.
- States: IDLE, LOAD, ISSUE, WAIT, DRAIN, GAP, HALT.
- IDLE:
  - Any reqN_valid → grant. If both are valid, grant the requester != last_grant.
  - Register grant id; next state LOAD.
  - No ready is asserted in IDLE.
- LOAD:
  - reqG_ready=1; the other ready=0.
  - Each handshake writes (x,y) at buffer[cnt] and increments cnt; prio is captured on the cnt==0 handshake.
  - Any x>4 or y>4 sets a sticky bad flag.
  - Handshake with last=1 ends LOAD. Handshake at cnt==24 with last=0 also ends LOAD, is treated as last, and pulses err_len.
  - On end: if bad, pulse err_coord, set last_grant=G, go to GAP (job dropped). Otherwise go to ISSUE.
- ISSUE:
  - Lasts exactly len=cnt cycles with kt_in_valid=1 and kt_in_x/y=buffer[k] for k=0..len-1.
  - kt_move_num=len and kt_priority_num=prio on k=0; both are 0 otherwise.
  - All kt_* outputs are 0 when kt_in_valid=0.
  - The first ISSUE cycle is the cycle after the final LOAD handshake.
- WAIT:
  - Counter starts at 0 and increments each cycle.
  - kt_out_valid=1 → DRAIN; that same cycle is forwarded.
  - Counter reaching TIMEOUT-1 with no kt_out_valid → HALT, pulse err_timeout.
- DRAIN:
  - Each kt_out_valid cycle registers res_* one cycle later (1-cycle latency): res_step=kt_move_out, res_x/y=kt_out_x/y, res_id=G, res_last=(kt_move_out==25).
  - After forwarding step 25: last_grant=G, go to GAP.
  - kt_out_valid low mid-burst is held in DRAIN without forwarding.
- GAP: counts GAP cycles, then IDLE. Requests are not sampled in GAP.
- HALT: busy=1, all ready=0, kt_in_valid=0. Exits only via rst_n.
- kt_out_valid outside WAIT/DRAIN is ignored.
- Back-to-back jobs from one requester are permitted. Fairness holds because the grant alternates whenever both requesters are pending in IDLE.

Test Plan:
- req0 job (0,0)(1,2)(2,4), last on 3rd, prio=3 → kt_in_valid 3 consecutive cycles; first cycle move_num=3, priority=3. Stub core returns 25 steps → res_valid 25 cycles, res_id=0, res_step 1..25, res_last on 25.
- req0 and req1 both valid at reset release → req0 served first, then req1. With req0 re-requesting during req1's job, req0 is served next; no starvation over 6 jobs.
- req1 streams 26 entries with no last → err_len pulse after the 25th handshake; ISSUE length 25; the 26th entry starts a new job.
- req0 entry (5,1) → err_coord pulse after last, no kt_in_valid, busy falls after GAP cycles.
- Stub core never responds, TIMEOUT=16 → err_timeout pulse 16 cycles after ISSUE ends; HALT holds busy=1 and readies low until rst_n.
- rst_n asserted mid-ISSUE → all outputs 0 asynchronously. After release, req0 wins the next tie and the full job replays correctly.

Source files
------------

// File: rtl/kt_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : kt_job_scheduler
// Brief    : Front end for the knight-tour solver core. Arbitrates tour jobs
//            from two valid/ready requesters round-robin, buffers the granted
//            path prefix, replays it to the core as one contiguous burst and
//            forwards the 25-step result burst tagged with the requester id.
// Revision : 1.0 - initial release
// ============================================================================
module kt_job_scheduler #(
    parameter int TIMEOUT = 4096,
    parameter int GAP     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_x,
    input  logic [2:0] req0_y,
    input  logic [2:0] req0_prio,
    input  logic       req0_last,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_x,
    input  logic [2:0] req1_y,
    input  logic [2:0] req1_prio,
    input  logic       req1_last,
    output logic       kt_in_valid,
    output logic [2:0] kt_in_x,
    output logic [2:0] kt_in_y,
    output logic [4:0] kt_move_num,
    output logic [2:0] kt_priority_num,
    input  logic       kt_out_valid,
    input  logic [2:0] kt_out_x,
    input  logic [2:0] kt_out_y,
    input  logic [4:0] kt_move_out,
    output logic       res_valid,
    output logic       res_id,
    output logic [4:0] res_step,
    output logic [2:0] res_x,
    output logic [2:0] res_y,
    output logic       res_last,
    output logic       busy,
    output logic       err_len,
    output logic       err_coord,
    output logic       err_timeout
);

    localparam int c_DEPTH  = 25;
    localparam int c_WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int c_GAP_W  = (GAP > 2) ? $clog2(GAP) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'(GAP - 1);
    localparam logic [4:0] c_LAST_IDX  = 5'd24;
    localparam logic [4:0] c_LAST_STEP = 5'd25;
    localparam logic [2:0] c_MAX_COORD = 3'd4;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_ISSUE = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_DRAIN = 3'd4;
    localparam logic [2:0] c_ST_GAP   = 3'd5;
    localparam logic [2:0] c_ST_HALT  = 3'd6;

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic                r_grant;
    logic                r_last_grant;
    logic [4:0]          r_cnt;
    logic [4:0]          r_len;
    logic [4:0]          r_k;
    logic [2:0]          r_prio;
    logic                r_bad;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic [2:0]          r_buf_x [c_DEPTH];
    logic [2:0]          r_buf_y [c_DEPTH];
    logic                r_err_len;
    logic                r_err_coord;
    logic                r_err_timeout;
    logic                r_res_valid;
    logic                r_res_id;
    logic [4:0]          r_res_step;
    logic [2:0]          r_res_x;
    logic [2:0]          r_res_y;
    logic                r_res_last;

    logic       w_sel_valid;
    logic [2:0] w_sel_x;
    logic [2:0] w_sel_y;
    logic [2:0] w_sel_prio;
    logic       w_sel_last;
    logic       w_pick;
    logic       w_any_req;
    logic       w_load_hs;
    logic       w_cnt_full;
    logic       w_load_end;
    logic       w_bad_any;
    logic       w_issue_end;
    logic       w_core_in;
    logic       w_core_done;
    logic       w_timeout;
    logic       w_gap_done;

    // Granted-requester mux, arbitration and handshake/event decode
    always_comb begin
        w_sel_valid = r_grant ? req1_valid : req0_valid;
        w_sel_x     = r_grant ? req1_x     : req0_x;
        w_sel_y     = r_grant ? req1_y     : req0_y;
        w_sel_prio  = r_grant ? req1_prio  : req0_prio;
        w_sel_last  = r_grant ? req1_last  : req0_last;
        w_any_req   = req0_valid | req1_valid;
        // On a tie the requester that did not finish the previous job wins
        w_pick      = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
        w_load_hs   = (r_state == c_ST_LOAD) && w_sel_valid;
        w_cnt_full  = (r_cnt == c_LAST_IDX);
        w_load_end  = w_load_hs && (w_sel_last || w_cnt_full);
        w_bad_any   = r_bad || (w_sel_x > c_MAX_COORD) || (w_sel_y > c_MAX_COORD);
        w_issue_end = (r_state == c_ST_ISSUE) && (r_k == r_len - 5'd1);
        w_core_in   = ((r_state == c_ST_WAIT) || (r_state == c_ST_DRAIN)) && kt_out_valid;
        w_core_done = w_core_in && (kt_move_out == c_LAST_STEP);
        w_timeout   = (r_state == c_ST_WAIT) && !kt_out_valid && (r_wait_cnt == c_WAIT_LAST);
        w_gap_done  = (r_state == c_ST_GAP) && (r_gap_cnt == c_GAP_LAST);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_any_req) w_next_state = c_ST_LOAD;
            c_ST_LOAD:  if (w_load_end) w_next_state = w_bad_any ? c_ST_GAP : c_ST_ISSUE;
            c_ST_ISSUE: if (w_issue_end) w_next_state = c_ST_WAIT;
            c_ST_WAIT: begin
                if (kt_out_valid) begin
                    w_next_state = (kt_move_out == c_LAST_STEP) ? c_ST_GAP : c_ST_DRAIN;
                end else if (w_timeout) begin
                    w_next_state = c_ST_HALT;
                end
            end
            c_ST_DRAIN: if (w_core_done) w_next_state = c_ST_GAP;
            c_ST_GAP:   if (w_gap_done) w_next_state = c_ST_IDLE;
            c_ST_HALT:  w_next_state = c_ST_HALT;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // State-decoded outputs; everything is zero outside its active state
    always_comb begin
        busy            = (r_state != c_ST_IDLE);
        req0_ready      = (r_state == c_ST_LOAD) && !r_grant;
        req1_ready      = (r_state == c_ST_LOAD) && r_grant;
        kt_in_valid     = 1'b0;
        kt_in_x         = 3'd0;
        kt_in_y         = 3'd0;
        kt_move_num     = 5'd0;
        kt_priority_num = 3'd0;
        if (r_state == c_ST_ISSUE) begin
            kt_in_valid = 1'b1;
            kt_in_x     = r_buf_x[r_k];
            kt_in_y     = r_buf_y[r_k];
            if (r_k == 5'd0) begin
                kt_move_num     = r_len;
                kt_priority_num = r_prio;
            end
        end
    end

    // Job bookkeeping: grant, prefix count, sticky bad flag and phase counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= 5'd0;
            r_len        <= 5'd0;
            r_k          <= 5'd0;
            r_prio       <= 3'd0;
            r_bad        <= 1'b0;
            r_wait_cnt   <= '0;
            r_gap_cnt    <= '0;
        end else begin
            r_k        <= (r_state == c_ST_ISSUE) ? r_k + 5'd1 : 5'd0;
            r_wait_cnt <= (r_state == c_ST_WAIT) ? r_wait_cnt + 1'b1 : '0;
            r_gap_cnt  <= (r_state == c_ST_GAP) ? r_gap_cnt + 1'b1 : '0;
            if (r_state == c_ST_IDLE) begin
                r_cnt <= 5'd0;
                r_bad <= 1'b0;
                if (w_any_req) begin
                    r_grant <= w_pick;
                end
            end
            if (w_load_hs) begin
                r_cnt <= r_cnt + 5'd1;
                r_bad <= w_bad_any;
                if (r_cnt == 5'd0) begin
                    r_prio <= w_sel_prio;
                end
            end
            if (w_load_end) begin
                r_len <= r_cnt + 5'd1;
            end
            // A job counts as served once it is dropped or fully drained
            if ((w_load_end && w_bad_any) || w_core_done) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Prefix buffer; contents are only read after being written for the job
    always_ff @(posedge clk) begin
        if (w_load_hs) begin
            r_buf_x[r_cnt] <= w_sel_x;
            r_buf_y[r_cnt] <= w_sel_y;
        end
    end

    // Single-cycle error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_len     <= 1'b0;
            r_err_coord   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_len     <= w_load_hs && w_cnt_full && !w_sel_last;
            r_err_coord   <= w_load_end && w_bad_any;
            r_err_timeout <= w_timeout;
        end
    end

    // Result forwarding with one cycle of latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_res_step  <= 5'd0;
            r_res_x     <= 3'd0;
            r_res_y     <= 3'd0;
            r_res_last  <= 1'b0;
        end else begin
            r_res_valid <= w_core_in;
            r_res_id    <= w_core_in ? r_grant : 1'b0;
            r_res_step  <= w_core_in ? kt_move_out : 5'd0;
            r_res_x     <= w_core_in ? kt_out_x : 3'd0;
            r_res_y     <= w_core_in ? kt_out_y : 3'd0;
            r_res_last  <= w_core_done;
        end
    end

    assign err_len     = r_err_len;
    assign err_coord   = r_err_coord;
    assign err_timeout = r_err_timeout;
    assign res_valid   = r_res_valid;
    assign res_id      = r_res_id;
    assign res_step    = r_res_step;
    assign res_x       = r_res_x;
    assign res_y       = r_res_y;
    assign res_last    = r_res_last;

endmodule
`default_nettype wire
